// File: rtl/zle_b_ctl_if.sv
// Stream handshake bundle for the zero run-length encoder controller.
// The master side is the environment (upstream source plus downstream sink);
// the slave side is the controller itself.
interface zle_b_ctl_if;
    logic       i_valid;
    logic       i_ready;
    logic       o_valid;
    logic       o_ready;
    logic [7:0] o_data;

    modport master (
        output i_valid,
        output o_ready,
        input  i_ready,
        input  o_valid,
        input  o_data
    );

    modport slave (
        input  i_valid,
        input  o_ready,
        output i_ready,
        output o_valid,
        output o_data
    );
endinterface

// File: rtl/zle_b_ctl.sv
// Controller for the 7->8 bit zero run-length encoder datapath: sequences the
// START/ZEROS/PENDING states, generates the datapath fire strobe from the
// stream handshakes, buffers one output token and keeps debug token counters.
module zle_b_ctl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    zle_b_ctl_if.slave       bus,
    input  logic [7:0]       dp_o_d,
    input  logic             f_start_i_eq_0,
    input  logic             f_zeros_i_eq_0,
    input  logic             f_zeros_cnt_eq_127,
    output logic [1:0]       state,
    output logic             fire,
    output logic [CNT_W-1:0] tok_in_cnt,
    output logic [CNT_W-1:0] tok_out_cnt
);

    localparam logic [1:0] ST_START   = 2'd0;
    localparam logic [1:0] ST_ZEROS   = 2'd1;
    localparam logic [1:0] ST_PENDING = 2'd2;

    logic [1:0]       state_q, state_d, nxt_state;
    logic             need_in, emit, legal, space, in_acc, out_acc, i_ready;
    logic             o_valid_q, o_valid_d;
    logic [7:0]       o_data_q, o_data_d;
    logic [CNT_W-1:0] tok_in_q, tok_in_d, tok_out_q, tok_out_d;

    // Per-state requirements: whether an input is consumed, whether a token
    // is emitted, and where the state goes if the datapath fires.
    always_comb begin
        need_in   = 1'b0;
        emit      = 1'b0;
        legal     = 1'b1;
        nxt_state = ST_START;
        case (state_q)
            ST_START: begin
                need_in   = 1'b1;
                emit      = !f_start_i_eq_0;
                nxt_state = f_start_i_eq_0 ? ST_ZEROS : ST_START;
            end
            ST_ZEROS: begin
                need_in = 1'b1;
                emit    = !f_zeros_i_eq_0 || f_zeros_cnt_eq_127;
                if (!f_zeros_i_eq_0) begin
                    nxt_state = ST_PENDING;
                end else if (f_zeros_cnt_eq_127) begin
                    nxt_state = ST_START;
                end else begin
                    nxt_state = ST_ZEROS;
                end
            end
            ST_PENDING: begin
                emit      = 1'b1;
                nxt_state = ST_START;
            end
            default: legal = 1'b0;
        endcase
    end

    // Fire when enabled, the input is there if needed, and the buffer has
    // room if we emit; reset is folded in so fire/i_ready stay low during it.
    always_comb begin
        space   = !o_valid_q || bus.o_ready;
        fire    = !reset && en && legal && (!need_in || bus.i_valid) && (!emit || space);
        i_ready = fire && need_in;
        in_acc  = bus.i_valid && i_ready;
        out_acc = o_valid_q && bus.o_ready;
    end

    // Next state, output buffer and counter updates.
    always_comb begin
        if (!legal) begin
            state_d = ST_START;
        end else if (fire) begin
            state_d = nxt_state;
        end else begin
            state_d = state_q;
        end

        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
        // Refill wins over drain so a simultaneous drain and reload leaves no bubble.
        if (fire && emit) begin
            o_data_d  = dp_o_d;
            o_valid_d = 1'b1;
        end else if (bus.o_ready) begin
            o_valid_d = 1'b0;
        end

        tok_in_d  = in_acc  ? tok_in_q + CNT_W'(1)  : tok_in_q;
        tok_out_d = out_acc ? tok_out_q + CNT_W'(1) : tok_out_q;
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_START;
            o_valid_q <= 1'b0;
            o_data_q  <= 8'd0;
            tok_in_q  <= '0;
            tok_out_q <= '0;
        end else begin
            state_q   <= state_d;
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
            tok_in_q  <= tok_in_d;
            tok_out_q <= tok_out_d;
        end
    end

    assign state       = state_q;
    assign bus.i_ready = i_ready;
    assign bus.o_valid = o_valid_q;
    assign bus.o_data  = o_data_q;
    assign tok_in_cnt  = tok_in_q;
    assign tok_out_cnt = tok_out_q;

endmodule

// File: tb/tb_zle_b_ctl.sv
// Self-checking bench for zle_b_ctl. A small behavioural encoder datapath
// supplies flags and dp_o_d; output tokens are collected and compared with
// a reference zero run-length encoding of the accepted input stream.
module tb_zle_b_ctl;

    logic        clock;
    logic        reset;
    logic        en;
    logic [6:0]  din;
    logic [7:0]  dp_o_d;
    logic        f_start_i_eq_0, f_zeros_i_eq_0, f_zeros_cnt_eq_127;
    logic [1:0]  state;
    logic        fire;
    logic [15:0] tok_in_cnt, tok_out_cnt;

    int checks = 0;
    int failures = 0;

    logic [7:0] got_q[$];

    zle_b_ctl_if bus ();

    zle_b_ctl #(.CNT_W(16)) dut (
        .clock              (clock),
        .reset              (reset),
        .en                 (en),
        .bus                (bus),
        .dp_o_d             (dp_o_d),
        .f_start_i_eq_0     (f_start_i_eq_0),
        .f_zeros_i_eq_0     (f_zeros_i_eq_0),
        .f_zeros_cnt_eq_127 (f_zeros_cnt_eq_127),
        .state              (state),
        .fire               (fire),
        .tok_in_cnt         (tok_in_cnt),
        .tok_out_cnt        (tok_out_cnt)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Behavioural encoder datapath: zero-run counter and held literal.
    logic [6:0] dp_cnt, dp_held;
    assign f_start_i_eq_0     = (din == 7'd0);
    assign f_zeros_i_eq_0     = (din == 7'd0);
    assign f_zeros_cnt_eq_127 = (dp_cnt == 7'd127);
    always_comb begin
        dp_o_d = 8'd0;
        case (state)
            2'd0: dp_o_d = {1'b0, din};
            2'd1: dp_o_d = {1'b1, dp_cnt};
            2'd2: dp_o_d = {1'b0, dp_held};
            default: dp_o_d = 8'd0;
        endcase
    end
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            dp_cnt  <= 7'd0;
            dp_held <= 7'd0;
        end else if (fire) begin
            if (state == 2'd0 && din == 7'd0) begin
                dp_cnt <= 7'd1;
            end else if (state == 2'd1) begin
                if (din != 7'd0) begin
                    dp_held <= din;
                    dp_cnt  <= 7'd0;
                end else if (dp_cnt == 7'd127) begin
                    dp_cnt <= 7'd0;
                end else begin
                    dp_cnt <= dp_cnt + 7'd1;
                end
            end
        end
    end

    // Sink: record every token transferred at the following rising edge.
    always @(negedge clock) begin
        if (!reset && bus.o_valid && bus.o_ready) got_q.push_back(bus.o_data);
    end

    task automatic do_reset;
        @(negedge clock);
        reset = 1'b1;
        en = 1'b0; bus.i_valid = 1'b0; bus.o_ready = 1'b0; din = 7'd0;
        @(posedge clock); #1;
        reset = 1'b0;
        got_q.delete();
    endtask

    task automatic test_reset;
        reset = 1'b1; en = 1'b1; bus.i_valid = 1'b1; bus.o_ready = 1'b1; din = 7'd5;
        #12;
        checks++; if (fire !== 1'b0) begin failures++; $display("FAIL reset_fire got=%b want=0", fire); end
        checks++; if (bus.i_ready !== 1'b0) begin failures++; $display("FAIL reset_i_ready got=%b want=0", bus.i_ready); end
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d want=0", state); end
        checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL reset_o_valid got=%b want=0", bus.o_valid); end
        checks++; if (bus.o_data !== 8'd0) begin failures++; $display("FAIL reset_o_data got=%h want=00", bus.o_data); end
        checks++; if (tok_in_cnt !== 16'd0 || tok_out_cnt !== 16'd0) begin
            failures++; $display("FAIL reset_counters got=%0d/%0d want=0/0", tok_in_cnt, tok_out_cnt); end
        do_reset;
    endtask

    task automatic test_literal;
        do_reset;
        en = 1'b1; bus.o_ready = 1'b1; din = 7'd5; bus.i_valid = 1'b1;
        @(negedge clock);
        checks++; if (fire !== 1'b1 || bus.i_ready !== 1'b1) begin
            failures++; $display("FAIL literal_fire got=%b/%b want=1/1", fire, bus.i_ready); end
        @(posedge clock); #1;
        bus.i_valid = 1'b0;
        checks++; if (bus.o_valid !== 1'b1 || bus.o_data !== 8'h05) begin
            failures++; $display("FAIL literal_out got=%b/%h want=1/05", bus.o_valid, bus.o_data); end
        checks++; if (state !== 2'd0 || tok_in_cnt !== 16'd1) begin
            failures++; $display("FAIL literal_state_cnt got=%0d/%0d want=0/1", state, tok_in_cnt); end
    endtask

    task automatic test_run_literal;
        logic [6:0] ins [4] = '{7'd0, 7'd0, 7'd0, 7'd9};
        logic [1:0] sts [4] = '{2'd0, 2'd1, 2'd1, 2'd1};
        do_reset;
        en = 1'b1; bus.o_ready = 1'b1; bus.i_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            din = ins[k];
            @(negedge clock);
            checks++; if (state !== sts[k] || fire !== 1'b1) begin
                failures++; $display("FAIL run_state[%0d] got=%0d/%b want=%0d/1", k, state, fire, sts[k]); end
            @(posedge clock); #1;
        end
        bus.i_valid = 1'b0; din = 7'd0;
        checks++; if (state !== 2'd2) begin failures++; $display("FAIL run_pending got=%0d want=2", state); end
        @(posedge clock); #1;
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL run_back_start got=%0d want=0", state); end
        @(posedge clock); #1;
        checks++; if (tok_in_cnt !== 16'd4 || tok_out_cnt !== 16'd2) begin
            failures++; $display("FAIL run_counters got=%0d/%0d want=4/2", tok_in_cnt, tok_out_cnt); end
        checks++; if (got_q.size() != 2 || got_q[0] !== 8'h83 || got_q[1] !== 8'h09) begin
            failures++; $display("FAIL run_tokens got=%p want=83,09", got_q); end
    endtask

    task automatic test_max_run;
        int bad_fire = 0;
        do_reset;
        en = 1'b1; bus.o_ready = 1'b1; bus.i_valid = 1'b1; din = 7'd0;
        for (int k = 1; k <= 128; k++) begin
            @(negedge clock);
            if (fire !== 1'b1) bad_fire++;
            if (k == 127) begin
                checks++; if (f_zeros_cnt_eq_127 !== 1'b0 || bus.o_valid !== 1'b0) begin
                    failures++; $display("FAIL maxrun_early got=%b/%b want=0/0", f_zeros_cnt_eq_127, bus.o_valid); end
            end
            if (k == 128) begin
                checks++; if (f_zeros_cnt_eq_127 !== 1'b1 || state !== 2'd1) begin
                    failures++; $display("FAIL maxrun_flag got=%b/%0d want=1/1", f_zeros_cnt_eq_127, state); end
            end
            @(posedge clock); #1;
        end
        bus.i_valid = 1'b0;
        checks++; if (bad_fire != 0) begin failures++; $display("FAIL maxrun_fire got=%0d stalls want=0", bad_fire); end
        checks++; if (state !== 2'd0 || tok_in_cnt !== 16'd128) begin
            failures++; $display("FAIL maxrun_end got=%0d/%0d want=0/128", state, tok_in_cnt); end
        checks++; if (bus.o_valid !== 1'b1 || bus.o_data !== 8'hFF) begin
            failures++; $display("FAIL maxrun_token got=%b/%h want=1/ff", bus.o_valid, bus.o_data); end
        @(posedge clock); #1;
        checks++; if (tok_out_cnt !== 16'd1 || got_q.size() != 1) begin
            failures++; $display("FAIL maxrun_out got=%0d/%0d want=1/1", tok_out_cnt, got_q.size()); end
    endtask

    task automatic test_backpressure;
        do_reset;
        en = 1'b1; bus.o_ready = 1'b1; din = 7'd5; bus.i_valid = 1'b1;
        @(posedge clock); #1;
        bus.o_ready = 1'b0; din = 7'd7;
        @(negedge clock);
        checks++; if (fire !== 1'b0 || bus.i_ready !== 1'b0) begin
            failures++; $display("FAIL bp_stall got=%b/%b want=0/0", fire, bus.i_ready); end
        @(posedge clock); #1;
        checks++; if (bus.o_data !== 8'h05 || bus.o_valid !== 1'b1) begin
            failures++; $display("FAIL bp_hold got=%b/%h want=1/05", bus.o_valid, bus.o_data); end
        din = 7'd0;
        @(negedge clock);
        checks++; if (fire !== 1'b1) begin failures++; $display("FAIL bp_zero_fire got=%b want=1", fire); end
        @(posedge clock); #1;
        bus.i_valid = 1'b0;
        checks++; if (state !== 2'd1 || bus.o_data !== 8'h05) begin
            failures++; $display("FAIL bp_zeros got=%0d/%h want=1/05", state, bus.o_data); end
    endtask

    task automatic test_pending_stall;
        do_reset;
        en = 1'b1; bus.o_ready = 1'b1; bus.i_valid = 1'b1; din = 7'd0;
        @(posedge clock); #1;
        din = 7'd4;
        @(posedge clock); #1;
        bus.o_ready = 1'b0; bus.i_valid = 1'b0; din = 7'd0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            checks++; if (state !== 2'd2 || fire !== 1'b0 || bus.o_data !== 8'h81) begin
                failures++; $display("FAIL pend_hold[%0d] got=%0d/%b/%h want=2/0/81", k, state, fire, bus.o_data); end
            @(posedge clock); #1;
        end
        bus.o_ready = 1'b1;
        @(negedge clock);
        checks++; if (fire !== 1'b1) begin failures++; $display("FAIL pend_release got=%b want=1", fire); end
        @(posedge clock); #1;
        checks++; if (state !== 2'd0 || bus.o_valid !== 1'b1 || bus.o_data !== 8'h04 || tok_out_cnt !== 16'd1) begin
            failures++; $display("FAIL pend_reload got=%0d/%b/%h/%0d want=0/1/04/1",
                                 state, bus.o_valid, bus.o_data, tok_out_cnt); end
    endtask

    task automatic test_enable;
        int bad = 0;
        do_reset;
        en = 1'b0; bus.o_ready = 1'b1; bus.i_valid = 1'b1; din = 7'd3;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (fire !== 1'b0 || bus.i_ready !== 1'b0) bad++;
            @(posedge clock); #1;
        end
        bus.i_valid = 1'b0;
        checks++; if (bad != 0) begin failures++; $display("FAIL en_low_fire got=%0d firing cycles want=0", bad); end
        checks++; if (tok_in_cnt !== 16'd0 || bus.o_valid !== 1'b0) begin
            failures++; $display("FAIL en_low_state got=%0d/%b want=0/0", tok_in_cnt, bus.o_valid); end
    endtask

    task automatic test_reset_mid;
        do_reset;
        en = 1'b1; bus.o_ready = 1'b1; bus.i_valid = 1'b1; din = 7'd5;
        @(posedge clock); #1;
        bus.o_ready = 1'b0; din = 7'd0;
        @(posedge clock); #1;
        bus.i_valid = 1'b0;
        checks++; if (state !== 2'd1 || bus.o_valid !== 1'b1) begin
            failures++; $display("FAIL midrst_setup got=%0d/%b want=1/1", state, bus.o_valid); end
        @(negedge clock); #2;
        reset = 1'b1;
        #1;
        checks++; if (state !== 2'd0 || bus.o_valid !== 1'b0 || bus.o_data !== 8'd0) begin
            failures++; $display("FAIL midrst_async got=%0d/%b/%h want=0/0/00", state, bus.o_valid, bus.o_data); end
        checks++; if (tok_in_cnt !== 16'd0 || tok_out_cnt !== 16'd0) begin
            failures++; $display("FAIL midrst_counters got=%0d/%0d want=0/0", tok_in_cnt, tok_out_cnt); end
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic test_random;
        logic [6:0] toks[$];
        logic [7:0] exp_q[$];
        logic [6:0] v;
        int run, idx, cyc, bad;
        do_reset;
        // Stream with short zero runs plus one long run crossing the 128 limit.
        for (int i = 0; i < 300; i++) begin
            if (i == 150) begin
                for (int z = 0; z < 131; z++) toks.push_back(7'd0);
            end
            if ($urandom_range(0, 9) < 5) toks.push_back(7'd0);
            else toks.push_back(7'($urandom_range(1, 127)));
        end
        toks.push_back(7'd42);
        // Reference encoding.
        run = 0;
        foreach (toks[i]) begin
            if (toks[i] == 7'd0) begin
                run++;
                if (run == 128) begin exp_q.push_back(8'hFF); run = 0; end
            end else begin
                if (run > 0) begin v = 7'(run); exp_q.push_back({1'b1, v}); run = 0; end
                exp_q.push_back({1'b0, toks[i]});
            end
        end
        idx = 0; cyc = 0;
        while ((idx < toks.size() || got_q.size() < exp_q.size()) && cyc < 20000) begin
            en          = ($urandom_range(0, 7) != 0);
            bus.i_valid = (idx < toks.size()) && ($urandom_range(0, 3) != 0);
            din         = (idx < toks.size()) ? toks[idx] : 7'd0;
            bus.o_ready = ($urandom_range(0, 3) != 0);
            @(negedge clock); #1;
            if (bus.i_valid && bus.i_ready) idx++;
            cyc++;
            @(posedge clock); #1;
        end
        bus.i_valid = 1'b0; bus.o_ready = 1'b0; din = 7'd0;
        checks++; if (cyc >= 20000) begin failures++; $display("FAIL rand_timeout got=%0d/%0d want=%0d/%0d",
                                                                idx, got_q.size(), toks.size(), exp_q.size()); end
        checks++; if (got_q.size() != exp_q.size()) begin
            failures++; $display("FAIL rand_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
        bad = 0;
        foreach (exp_q[i]) if (i < got_q.size() && got_q[i] !== exp_q[i]) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL rand_tokens got=%0d wrong want=0", bad); end
        checks++; if (tok_in_cnt !== 16'(toks.size()) || tok_out_cnt !== 16'(exp_q.size())) begin
            failures++; $display("FAIL rand_counters got=%0d/%0d want=%0d/%0d",
                                 tok_in_cnt, tok_out_cnt, toks.size(), exp_q.size()); end
    endtask

    initial begin
        din = 7'd0;
        test_reset;
        test_literal;
        test_run_literal;
        test_max_run;
        test_backpressure;
        test_pending_stall;
        test_enable;
        test_reset_mid;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/zle_b_ctl.md
# zle_b_ctl

Controller for the 7->8 bit zero run-length encoder datapath. It sequences the datapath's three encoding states and generates its `fire` strobe from the stream handshakes. It registers the datapath's combinational output into a one-entry output buffer and keeps token counters for debug. It sits between the upstream 7-bit stream source, the encoder datapath, and the downstream 8-bit sink.

## Interface
Parameters:
- `ST_START`, 2'd0, state code: literal / run-begin.
- `ST_ZEROS`, 2'd1, state code: counting zero run.
- `ST_PENDING`, 2'd2, state code: emit held non-zero literal.
- `CNT_W`, 16, width of debug token counters.

Ports:
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high. The datapath's active-low reset is driven from inverted `reset` at top level.
- `en` in 1: global enable; low freezes all firing.
- `i_valid` in 1: upstream token present on datapath `i_d`.
- `i_ready` out 1: input token consumed this cycle.
- `o_valid` out 1: output buffer holds a token.
- `o_ready` in 1: downstream accepts `o_data`.
- `o_data` out 8: buffered encoded token.
- `dp_o_d` in 8: datapath combinational output.
- `f_start_i_eq_0`, `f_zeros_i_eq_0`, `f_zeros_cnt_eq_127` in 1 each: datapath flags.
- `state` out 2: current state to datapath.
- `fire` out 1: datapath firing strobe.
- `tok_in_cnt` out CNT_W: accepted input tokens, wraps.
- `tok_out_cnt` out CNT_W: delivered output tokens, wraps.

## Operation
Per-state requirements (combinational):
- START: needs input. Emits iff `!f_start_i_eq_0`.
- ZEROS: needs input. Emits iff `!f_zeros_i_eq_0 || f_zeros_cnt_eq_127`.
- PENDING: needs no input. Always emits.
- Code 2'd3: illegal. `fire`=0; next state START.

Firing:
- `space = !o_valid || o_ready`.
- `fire = en && (!need_in || i_valid) && (!emit || space)`.
- `i_ready = fire && need_in`. `i_ready` may depend on `i_valid`; the source must not make `i_valid` depend on `i_ready`.

State transitions (on `fire` only):
- START: zero input -> ZEROS. Non-zero input -> START, literal emitted.
- ZEROS, zero input, cnt!=127 -> ZEROS.
- ZEROS, zero input, cnt==127 -> START, max-run token emitted.
- ZEROS, non-zero input -> PENDING. Run token emitted; datapath captures the literal.
- PENDING -> START, held literal emitted.

Output buffer:
- On `fire && emit`: `o_data <= dp_o_d`, `o_valid <= 1`.
- Else if `o_ready`: `o_valid <= 0`.
- `o_data` holds its value while `o_valid && !o_ready`.

Counters:
- `tok_in_cnt` +1 on `i_valid && i_ready`.
- `tok_out_cnt` +1 on `o_valid && o_ready`.
- Both wrap modulo 2^CNT_W.

## Timing
- Reset values: `state`=ST_START, `o_valid`=0, `o_data`=8'd0, both counters 0. Combinational outputs `fire`=0 and `i_ready`=0 while in reset.
- Latency: a token accepted in cycle N that emits appears on `o_data`/`o_valid` in cycle N+1. PENDING emission follows in the cycle after the non-zero input is accepted, if space.
- Throughput: one input per cycle with `o_ready`=1.
- A zero run followed by a literal costs one extra cycle (PENDING).
- Simultaneous drain and refill: `o_valid && o_ready && fire && emit` reloads the buffer and keeps `o_valid`=1. No bubble.
- Back-pressure: with the buffer full and `o_ready`=0, emitting states do not fire. A zero input in START, or a non-max zero in ZEROS, still fires (no emission needed).
- `en` low: `fire`=0, `i_ready`=0. The buffer still drains.
- Reset mid-operation: asynchronous. The buffered token and the in-progress run are discarded. Outputs take reset values immediately.

## Test plan
- Reset, `o_ready`=1, input 7'd5 -> `fire`=1, `i_ready`=1. Next cycle `o_valid`=1, `o_data`=dp value, `state` stays 0, `tok_in_cnt`=1.
- Inputs 0,0,0,9 back-to-back -> `state` sequence 0,1,1,1,2,0. Two output tokens: run token, then literal. `tok_in_cnt`=4, `tok_out_cnt`=2.
- 128 consecutive zeros -> flag `f_zeros_cnt_eq_127` on the 128th. One emission, `state` returns to 0, `tok_in_cnt`=128, `tok_out_cnt`=1.
- Buffer full, `o_ready`=0, non-zero input in START -> `fire`=0, `i_ready`=0, `o_data` stable. Change the input to zero -> `fire`=1, `state`->1.
- PENDING with `o_ready`=0 and buffer full -> `state` holds 2. Raise `o_ready` -> same-cycle drain and reload, `state`->0. Separately, `en`=0 with valid input -> no fire for 10 cycles.
- Assert `reset` mid-run in ZEROS with `o_valid`=1 -> `state`=0, `o_valid`=0, counters 0 without waiting for a clock edge.
